mac_exec_seq: RTL and testbench
===============================

Name: mac_exec_seq

Overview:
- Parametrised execution sequencer for the matrix-vector datapath.
- Runs after the memory controller has filled the ROWS A-FIFOs and the B-FIFO.
- Drives FIFO read enables and MAC enable/clear, drains the MAC pipeline, captures the ROWS accumulator results and handshakes done.
- Replaces hand-sequenced exec phases. Adds broadcast and skewed (systolic) modes, empty-FIFO stall, and a stall counter.

Parameters:
ROWS, 8, number of A-FIFO lanes / MAC lanes
VEC_LEN, 8, number of MAC steps per run (reads issued per lane)
DATA_WIDTH, 8, FIFO data width (informational, sets ACC_WIDTH default)
ACC_WIDTH, 3*DATA_WIDTH, width of each MAC accumulator result
MAC_LAT, 1, cycles from last mac_en to accumulator valid

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  level/pulse; sampled in IDLE only
skew_mode  in  1  sampled with start: 0 = broadcast, 1 = skewed
a_empty  in  ROWS  A-FIFO empty flags
b_empty  in  1  B-FIFO empty flag
a_rden  out  ROWS  A-FIFO read enables
b_rden  out  1  B-FIFO read enable
mac_en  out  ROWS  per-lane MAC enable
mac_clr  out  1  MAC accumulator clear
c_in  in  ROWS*ACC_WIDTH  MAC accumulators, lane r at [r*ACC_WIDTH +: ACC_WIDTH]
c_out  out  ROWS*ACC_WIDTH  captured results, same packing
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse on capture
result_valid  out  1  high after done until next accepted start
stall_cnt  out  16  stalled cycles in current/last run, saturating at 16'hFFFF

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0: rden, mac_en, mac_clr, c_out, busy, done, result_valid, stall_cnt. An in-flight run is abandoned with no capture.
- FIFO reads are registered: data from a read issued in cycle k is valid in k+1. mac_en[r] is therefore a_rden[r] delayed one cycle (registered, cleared by reset).
- IDLE: on start=1, latch skew_mode, then go to CLEAR.
  - Entering CLEAR: busy=1, result_valid=0, stall_cnt=0.
  - start while busy is ignored.
- CLEAR (1 cycle): mac_clr=1, no reads. Next state RUN with step counter k=0.
- RUN: step index k runs 0..LAST.
  - Broadcast: LAST=VEC_LEN-1. All lanes active at every k.
  - Skewed: LAST=VEC_LEN+ROWS-2. Lane r is active when r <= k < r+VEC_LEN.
  - b_rden follows lane 0's schedule.
  - Stall: if any active lane has a_empty=1, or b_rden would be 1 with b_empty=1, then no rden is asserted that cycle, k holds, and stall_cnt increments (saturating).
  - Otherwise active lanes get rden=1 and k increments. After k=LAST issues, go to DRAIN.
  - Total reads per lane are exactly VEC_LEN. A read is never issued to an empty FIFO.
- DRAIN: wait 1+MAC_LAT cycles after the last rden (covers the final mac_en plus MAC latency), then go to CAPTURE.
- CAPTURE (1 cycle):
  - c_out <= c_in, done=1, result_valid=1, busy=0.
  - Next state IDLE. c_out holds until the next capture or reset.
- Latency, broadcast, no stalls: start to done = 1 (CLEAR) + VEC_LEN + 1 + MAC_LAT + 1 cycles.
  - Defaults give 12 cycles.
  - Skewed adds ROWS-1 cycles.
- mac_clr and mac_en are never high in the same cycle.
- start held high through done re-triggers on the cycle after return to IDLE.

Test Plan:
- Broadcast, all FIFOs preloaded with 8 entries (A lane r = r+1, B = 2), default params -> exactly 8 rden pulses per lane; c_in model gives c_out lane r = 16*(r+1); done at cycle 12 after start; stall_cnt=0.
- Skewed mode, same data -> lane r rden high in cycles k=r..r+7; mac_en[r] is rden[r] delayed 1; done at cycle 19; same c_out values.
- Broadcast with B-FIFO empty for 3 cycles at k=4 -> rden all low for those 3 cycles; stall_cnt=3; total reads still 8; done 3 cycles later than baseline.
- Assert rst_n=0 at RUN k=5 -> all outputs 0 immediately (async); after release, state IDLE; new start completes normally with correct c_out.
- start pulsed during RUN, then held high after done -> mid-run pulse ignored (single run); held start launches a second run one cycle after IDLE; result_valid drops on entering CLEAR.
- ROWS=4, VEC_LEN=16, MAC_LAT=2, broadcast -> 16 reads per lane; done at cycle 1+16+3+1=21; c_out packing correct for 4 lanes.

Source files
------------

// File: rtl/mac_exec_seq.sv
// Execution sequencer for the matrix-vector datapath: drives the FIFO reads and the MAC
// enable/clear, drains the MAC pipeline, then captures the ROWS accumulators.
// state   | meaning
// IDLE    | waiting for start
// CLEAR   | one-cycle accumulator clear
// RUN     | issue reads, step k = 0..LAST, holds on empty FIFOs
// DRAIN   | 1+MAC_LAT cycles for the final mac_en and MAC latency
// CAPTURE | results registered, done pulse
module mac_exec_seq #(
  parameter int ROWS       = 8,
  parameter int VEC_LEN    = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 3*DATA_WIDTH,
  parameter int MAC_LAT    = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      skew_mode,
  input  logic [ROWS-1:0]           a_empty,
  input  logic                      b_empty,
  output logic [ROWS-1:0]           a_rden,
  output logic                      b_rden,
  output logic [ROWS-1:0]           mac_en,
  output logic                      mac_clr,
  input  logic [ROWS*ACC_WIDTH-1:0] c_in,
  output logic [ROWS*ACC_WIDTH-1:0] c_out,
  output logic                      busy,
  output logic                      done,
  output logic                      result_valid,
  output logic [15:0]               stall_cnt
);
  localparam int KMAX = VEC_LEN + ROWS + MAC_LAT;
  localparam int KW   = $clog2(KMAX + 1);
  localparam logic [KW-1:0] LAST_BC    = KW'(VEC_LEN - 1);
  localparam logic [KW-1:0] LAST_SK    = KW'(VEC_LEN + ROWS - 2);
  localparam logic [KW-1:0] DRAIN_LAST = KW'(MAC_LAT);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_DRAIN, S_CAPTURE} state_t;

  state_t          state, state_nx;
  logic [KW-1:0]   k, k_nx;
  logic [KW-1:0]   last_k;
  logic            skew_q;
  logic [ROWS-1:0] active;
  logic            stall;

  // Skewed lane r is live for steps r .. r+VEC_LEN-1; broadcast keeps every lane live.
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      active[r] = !skew_q || ((k >= KW'(r)) && (k < KW'(r + VEC_LEN)));
    end
  end

  always_comb begin
    state_nx = state;
    k_nx     = k;
    a_rden   = '0;
    b_rden   = 1'b0;
    mac_clr  = 1'b0;
    stall    = 1'b0;
    last_k   = skew_q ? LAST_SK : LAST_BC;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_CLEAR;
      end
      S_CLEAR: begin
        mac_clr  = 1'b1;
        k_nx     = '0;
        state_nx = S_RUN;
      end
      S_RUN: begin
        // B reads ride on lane 0's schedule, so B emptiness matters only while lane 0 is live.
        stall = (|(active & a_empty)) || (active[0] && b_empty);
        if (!stall) begin
          a_rden = active;
          b_rden = active[0];
          if (k == last_k) begin
            k_nx     = '0;
            state_nx = S_DRAIN;
          end else begin
            k_nx = k + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (k == DRAIN_LAST) state_nx = S_CAPTURE;
        else                 k_nx     = k + 1'b1;
      end
      S_CAPTURE: state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      k            <= '0;
      skew_q       <= 1'b0;
      mac_en       <= '0;
      c_out        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result_valid <= 1'b0;
      stall_cnt    <= '0;
    end else begin
      state  <= state_nx;
      k      <= k_nx;
      mac_en <= a_rden;
      done   <= 1'b0;
      if (state == S_IDLE && start) begin
        skew_q       <= skew_mode;
        busy         <= 1'b1;
        result_valid <= 1'b0;
        stall_cnt    <= '0;
      end
      if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      // Accumulators are valid on the last DRAIN cycle; results appear with done in CAPTURE.
      if (state == S_DRAIN && state_nx == S_CAPTURE) begin
        c_out        <= c_in;
        done         <= 1'b1;
        result_valid <= 1'b1;
        busy         <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_exec_seq.sv
// Bench for mac_exec_seq: FIFO and MAC environment models around two parameterisations,
// expected results computed as plain dot products of the data pushed into the FIFOs.
`timescale 1ns/1ps
module tb_mac_exec_seq;
  localparam int R = 8, V = 8, AW = 24;
  localparam int R2 = 4, V2 = 16, AW2 = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start = 1'b0, skew_mode = 1'b0;
  logic [R-1:0] a_empty = '1, a_rden, mac_en;
  logic b_empty = 1'b1, b_rden, mac_clr;
  logic [R*AW-1:0] c_in = '0, c_out;
  logic busy, done, result_valid;
  logic [15:0] stall_cnt;

  logic start2 = 1'b0;
  logic [R2-1:0] a_empty2 = '0, a_rden2, mac_en2;
  logic b_rden2, mac_clr2;
  logic [R2*AW2-1:0] c_in2 = '0, c_out2;
  logic busy2, done2, result_valid2;
  logic [15:0] stall_cnt2;

  mac_exec_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .skew_mode(skew_mode),
    .a_empty(a_empty), .b_empty(b_empty), .a_rden(a_rden), .b_rden(b_rden),
    .mac_en(mac_en), .mac_clr(mac_clr), .c_in(c_in), .c_out(c_out),
    .busy(busy), .done(done), .result_valid(result_valid), .stall_cnt(stall_cnt));

  mac_exec_seq #(.ROWS(R2), .VEC_LEN(V2), .DATA_WIDTH(8), .ACC_WIDTH(AW2), .MAC_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .skew_mode(1'b0),
    .a_empty(a_empty2), .b_empty(1'b0), .a_rden(a_rden2), .b_rden(b_rden2),
    .mac_en(mac_en2), .mac_clr(mac_clr2), .c_in(c_in2), .c_out(c_out2),
    .busy(busy2), .done(done2), .result_valid(result_valid2), .stall_cnt(stall_cnt2));

  int unsigned a_q[R][$];
  int unsigned b_q[$];
  int unsigned a_ref[R][$];
  int unsigned b_ref[$];
  int unsigned a_reg[R], a_nxt[R], b_reg, b_nxt;
  logic [AW-1:0] acc[R];
  logic [R-1:0] p_en = '0, p_rden = '0;
  logic p_clr = 1'b0;

  int unsigned a2_val[R2], b2_val;
  logic [AW2-1:0] acc2[R2];
  logic [R2-1:0] p_en2 = '0, p_rden2 = '0;
  logic p_clr2 = 1'b0;
  int rd2_cnt[R2], done2_cnt, done2_cyc;

  int cyc_n = 0, tests = 0, fails = 0;
  int rd_cnt[R], first_rd[R];
  int done_cnt, done_cyc, hold_rd, en_err, empty_err, clr_err;
  int b_hold_lo = 1, b_hold_hi = 0, a_hold_lane = 0, a_hold_lo = 1, a_hold_hi = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply last cycle's MAC/FIFO effects, drive inputs, then observe outputs.
  task automatic cyc();
    bit in_hold;
    @(negedge clk);
    cyc_n++;
    for (int r = 0; r < R; r++) begin
      if (p_clr) acc[r] = '0;
      if (p_en[r]) acc[r] = acc[r] + AW'(a_reg[r] * b_reg);
      a_reg[r] = a_nxt[r];
      c_in[r*AW +: AW] = acc[r];
      a_empty[r] = (a_q[r].size() == 0) ||
                   (r == a_hold_lane && cyc_n >= a_hold_lo && cyc_n <= a_hold_hi);
    end
    b_reg = b_nxt;
    b_empty = (b_q.size() == 0) || (cyc_n >= b_hold_lo && cyc_n <= b_hold_hi);
    in_hold = (cyc_n >= b_hold_lo && cyc_n <= b_hold_hi) || (cyc_n >= a_hold_lo && cyc_n <= a_hold_hi);
    for (int r = 0; r < R2; r++) begin
      c_in2[r*AW2 +: AW2] = acc2[r];
      if (p_clr2) acc2[r] = '0;
      if (p_en2[r]) acc2[r] = acc2[r] + AW2'(a2_val[r] * b2_val);
    end
    #1;
    if (rst_n) begin
      for (int r = 0; r < R; r++) begin
        if (mac_en[r] !== p_rden[r]) en_err++;
        if (a_rden[r]) begin
          if (a_empty[r]) empty_err++;
          else begin
            a_nxt[r] = a_q[r].pop_front();
            rd_cnt[r]++;
            if (first_rd[r] < 0) first_rd[r] = cyc_n;
          end
        end
      end
      if (b_rden) begin
        if (b_empty) empty_err++;
        else b_nxt = b_q.pop_front();
      end
      if (mac_clr && mac_en != '0) clr_err++;
      if (in_hold && (a_rden != '0 || b_rden)) hold_rd++;
      if (done) begin done_cnt++; done_cyc = cyc_n; end
      p_en = mac_en; p_clr = mac_clr; p_rden = a_rden;
      for (int r = 0; r < R2; r++) begin
        if (mac_en2[r] !== p_rden2[r]) en_err++;
        if (a_rden2[r]) rd2_cnt[r]++;
      end
      if (done2) begin done2_cnt++; done2_cyc = cyc_n; end
      p_en2 = mac_en2; p_clr2 = mac_clr2; p_rden2 = a_rden2;
    end else begin
      p_en = '0; p_clr = 1'b0; p_rden = '0;
      p_en2 = '0; p_clr2 = 1'b0; p_rden2 = '0;
    end
  endtask

  task automatic clear_stats();
    for (int r = 0; r < R; r++) begin rd_cnt[r] = 0; first_rd[r] = -1; end
    done_cnt = 0; hold_rd = 0; en_err = 0; empty_err = 0; clr_err = 0;
    b_hold_lo = 1; b_hold_hi = 0; a_hold_lo = 1; a_hold_hi = 0;
  endtask

  task automatic flush();
    for (int r = 0; r < R; r++) begin a_q[r].delete(); a_ref[r].delete(); end
    b_q.delete(); b_ref.delete();
  endtask

  task automatic load(input int n, input bit fixed, input bit const_b);
    int unsigned bc, v;
    bc = $urandom_range(1, 255);
    for (int j = 0; j < n; j++) begin
      for (int r = 0; r < R; r++) begin
        v = fixed ? r + 1 : $urandom_range(0, 255);
        a_q[r].push_back(v); a_ref[r].push_back(v);
      end
      v = fixed ? 2 : (const_b ? bc : $urandom_range(0, 255));
      b_q.push_back(v); b_ref.push_back(v);
    end
  endtask

  function automatic longint exp_c(input int r, input int off);
    longint s = 0;
    for (int j = 0; j < V; j++) s += longint'(a_ref[r][off+j]) * longint'(b_ref[off+j]);
    return s & ((longint'(1) << AW) - 1);
  endfunction

  task automatic launch(input bit skew, output int s);
    skew_mode = skew;
    s = cyc_n;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n0 = done_cnt;
    int i = 0;
    while (done_cnt == n0 && i < budget) begin cyc(); i++; end
    check({tag, "_done_seen"}, done_cnt - n0, 1);
  endtask

  task automatic check_run(input string tag, input int s, input int lat, input int stalls,
                           input int off, input int reads);
    int bad = 0;
    check({tag, "_latency"}, done_cyc - s, lat);
    for (int r = 0; r < R; r++)
      check($sformatf("%s_c_lane%0d", tag, r), longint'(c_out[r*AW +: AW]), exp_c(r, off));
    for (int r = 0; r < R; r++) if (rd_cnt[r] != reads) bad++;
    check({tag, "_lanes_wrong_read_count"}, bad, 0);
    check({tag, "_stall_cnt"}, stall_cnt, stalls);
    check({tag, "_result_valid"}, result_valid, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_mac_en_not_rden_delayed"}, en_err, 0);
    check({tag, "_read_of_empty"}, empty_err, 0);
    check({tag, "_clr_with_en"}, clr_err, 0);
    check({tag, "_reads_during_stall"}, hold_rd, 0);
    cyc();
    check({tag, "_done_is_pulse"}, done, 0);
  endtask

  initial begin
    int s, lane, bad;
    for (int r = 0; r < R; r++) begin acc[r] = '0; a_reg[r] = 0; a_nxt[r] = 0; end
    for (int r = 0; r < R2; r++) acc2[r] = '0;
    b_reg = 0; b_nxt = 0;
    clear_stats();
    repeat (3) cyc();
    check("reset_outs", {a_rden, b_rden, mac_en, mac_clr, busy, done, result_valid, stall_cnt}, 0);
    check("reset_c_out_nonzero", longint'(|c_out), 0);
    check("reset_c_out2_nonzero", longint'(|c_out2), 0);
    rst_n = 1'b1;
    cyc();

    // Broadcast, fixed data: lane r -> 8*(r+1)*2
    flush(); load(8, 1'b1, 1'b0); clear_stats(); cyc();
    launch(1'b0, s); wait_done("bc_fixed", 40);
    check("bc_fixed_lane7_value", longint'(c_out[7*AW +: AW]), 128);
    check_run("bc_fixed", s, 12, 0, 0, 8);

    // Broadcast, random data
    flush(); load(8, 1'b0, 1'b0); clear_stats(); cyc();
    launch(1'b0, s); wait_done("bc_rand", 40);
    check_run("bc_rand", s, 12, 0, 0, 8);

    // Skewed, random A, constant B
    flush(); load(8, 1'b0, 1'b1); clear_stats(); cyc();
    launch(1'b1, s); wait_done("skew", 60);
    for (int r = 0; r < R; r++) check($sformatf("skew_first_read_lane%0d", r), first_rd[r] - s, 2 + r);
    check_run("skew", s, 19, 0, 0, 8);

    // Broadcast, B-FIFO empty for 3 cycles starting at k=4
    flush(); load(8, 1'b0, 1'b0); clear_stats(); cyc();
    b_hold_lo = cyc_n + 6; b_hold_hi = cyc_n + 8;
    launch(1'b0, s); wait_done("b_stall", 60);
    check_run("b_stall", s, 15, 3, 0, 8);

    // Broadcast, one random A lane empty for 2 cycles starting at k=2
    flush(); load(8, 1'b0, 1'b0); clear_stats(); cyc();
    lane = $urandom_range(0, R-1);
    a_hold_lane = lane; a_hold_lo = cyc_n + 4; a_hold_hi = cyc_n + 5;
    launch(1'b0, s); wait_done("a_stall", 60);
    check_run("a_stall", s, 14, 2, 0, 8);

    // Async reset in RUN at k=5
    flush(); load(8, 1'b0, 1'b0); clear_stats(); cyc();
    launch(1'b0, s);
    while (cyc_n < s + 7) cyc();
    check("pre_reset_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outs", {a_rden, b_rden, mac_en, mac_clr, busy, done, result_valid, stall_cnt}, 0);
    check("async_reset_c_out_nonzero", longint'(|c_out), 0);
    repeat (2) cyc();
    rst_n = 1'b1;
    flush(); load(8, 1'b0, 1'b0); clear_stats(); cyc();
    check("post_reset_idle_busy", busy, 0);
    launch(1'b0, s); wait_done("post_reset", 40);
    check_run("post_reset", s, 12, 0, 0, 8);

    // Start pulsed mid-run is ignored; start held through done re-triggers
    flush(); load(16, 1'b0, 1'b0); clear_stats(); cyc();
    launch(1'b0, s);
    while (cyc_n < s + 5) cyc();
    start = 1'b1; cyc(); start = 1'b0;
    while (cyc_n < s + 10) cyc();
    start = 1'b1;
    wait_done("held1", 40);
    check_run("held1", s, 12, 0, 0, 8);
    check("held_idle_result_valid", result_valid, 1);
    cyc();
    check("held_clear_result_valid", result_valid, 0);
    check("held_clear_busy", busy, 1);
    check("held_clear_mac_clr", mac_clr, 1);
    start = 1'b0;
    clear_stats();
    wait_done("held2", 40);
    check_run("held2", s, 25, 0, 8, 8);
    repeat (4) cyc();
    check("held_no_third_run_busy", busy, 0);
    check("held_no_extra_done", done_cnt, 1);

    // ROWS=4, VEC_LEN=16, MAC_LAT=2 instance
    for (int r = 0; r < R2; r++) begin a2_val[r] = $urandom_range(1, 255); rd2_cnt[r] = 0; end
    b2_val = $urandom_range(1, 255);
    done2_cnt = 0; en_err = 0;
    s = cyc_n; start2 = 1'b1; cyc(); start2 = 1'b0;
    while (done2_cnt == 0 && cyc_n < s + 60) cyc();
    check("r4_done_seen", done2_cnt, 1);
    check("r4_latency", done2_cyc - s, 21);
    bad = 0;
    for (int r = 0; r < R2; r++) if (rd2_cnt[r] != V2) bad++;
    check("r4_lanes_wrong_read_count", bad, 0);
    for (int r = 0; r < R2; r++)
      check($sformatf("r4_c_lane%0d", r), longint'(c_out2[r*AW2 +: AW2]),
            (longint'(V2) * a2_val[r] * b2_val) & ((longint'(1) << AW2) - 1));
    check("r4_stall_cnt", stall_cnt2, 0);
    check("r4_mac_en_not_rden_delayed", en_err, 0);
    check("r4_result_valid", result_valid2, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
